// File: rtl/sad44_min_search.sv
// sad44_min_search
//   Motion-search back end. Latches a 4x4 current block on start, then takes
//   candidate blocks as 4 row-beats each, computes each candidate's 4x4 SAD
//   in a 3-stage pipeline and tracks the minimum SAD and its index.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   cur_blk     current block, pixel 00 at MSBs, row-major
//   start       begin a search (sampled in IDLE only)
//   cand_row    one candidate row, leftmost pixel at MSBs
//   cand_valid  cand_row valid this cycle (gaps allowed)
//   busy        high from start acceptance until the final compare commits
//   sad_out     SAD of the most recently completed candidate
//   sad_valid   one-cycle pulse, sad_out is new
//   best_sad    running minimum SAD (all ones before the first candidate)
//   best_idx    candidate index of best_sad
//   done        one-cycle pulse, search complete
module sad44_min_search #(
  parameter int WORD_WIDETH = 8,
  parameter int CAND_NUM    = 64,
  parameter int IDX_W       = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_WIDETH*16-1:0] cur_blk,
  input  logic                     start,
  input  logic [WORD_WIDETH*4-1:0] cand_row,
  input  logic                     cand_valid,
  output logic                     busy,
  output logic [WORD_WIDETH+3:0]   sad_out,
  output logic                     sad_valid,
  output logic [WORD_WIDETH+3:0]   best_sad,
  output logic [IDX_W-1:0]         best_idx,
  output logic                     done
);

  localparam int WW = WORD_WIDETH;
  localparam int RW = WORD_WIDETH + 2;  // one row of 4 differences
  localparam int SW = WORD_WIDETH + 4;  // full 16-pixel SAD
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CAND_NUM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE_WAIT} state_t;

  state_t state, state_nxt;

  logic [WW*16-1:0] cur_q;
  logic [1:0]       row_cnt;
  logic [IDX_W-1:0] cand_idx;

  // Stage 1: absolute differences plus the beat's tags
  logic [WW-1:0]    diff_q [4];
  logic [WW-1:0]    diff_nxt [4];
  logic             d_valid, d_first, d_last, d_final;
  logic [IDX_W-1:0] d_idx;

  // Stage 2: accumulation; sad_valid doubles as the compare-stage valid
  logic [SW-1:0]    acc;
  logic [RW-1:0]    row_sum;
  logic [SW-1:0]    acc_sum;
  logic [IDX_W-1:0] c_idx;
  logic             c_final;

  logic [4*WW-1:0]  cur_row;
  logic             start_acc, beat_acc, last_beat, final_cmp;

  assign start_acc = (state == IDLE) && start;
  assign beat_acc  = (state == RUN) && cand_valid;
  assign last_beat = beat_acc && (row_cnt == 2'd3) && (cand_idx == LAST_IDX);
  assign final_cmp = sad_valid && c_final;

  // ---------------------------------------------------------------- FSM
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment at the top keeps this block free of
  // inferred latches on paths that do not assign state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start)     state_nxt = RUN;
      RUN:       if (last_beat) state_nxt = DONE_WAIT;
      DONE_WAIT: if (final_cmp) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // ------------------------------------------- block latch and counters
  // NOTE: the latched current block is a plain register bank, so it is
  // cleared by reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q    <= '0;
      row_cnt  <= '0;
      cand_idx <= '0;
    end else if (start_acc) begin
      cur_q    <= cur_blk;
      row_cnt  <= '0;
      cand_idx <= '0;
    end else if (beat_acc) begin
      row_cnt <= row_cnt + 2'd1;
      if (row_cnt == 2'd3)
        cand_idx <= (cand_idx == LAST_IDX) ? '0 : cand_idx + 1'b1;
    end
  end

  // ------------------------------------------------ stage 1: |a - b|
  always_comb begin
    cur_row = cur_q[(3 - int'(row_cnt))*4*WW +: 4*WW];
    for (int j = 0; j < 4; j++) begin
      diff_nxt[j] = '0;
      if (cur_row[(3-j)*WW +: WW] >= cand_row[(3-j)*WW +: WW])
        diff_nxt[j] = cur_row[(3-j)*WW +: WW] - cand_row[(3-j)*WW +: WW];
      else
        diff_nxt[j] = cand_row[(3-j)*WW +: WW] - cur_row[(3-j)*WW +: WW];
    end
  end

  // Differences hold through cand_valid gaps; only the valid bit drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) diff_q[j] <= '0;
      d_valid <= 1'b0;
      d_first <= 1'b0;
      d_last  <= 1'b0;
      d_final <= 1'b0;
      d_idx   <= '0;
    end else begin
      d_valid <= beat_acc;
      if (beat_acc) begin
        for (int j = 0; j < 4; j++) diff_q[j] <= diff_nxt[j];
        d_first <= (row_cnt == 2'd0);
        d_last  <= (row_cnt == 2'd3);
        d_final <= last_beat;
        d_idx   <= cand_idx;
      end
    end
  end

  // ------------------------------------------- stage 2: accumulate
  always_comb begin
    row_sum = RW'(diff_q[0]) + RW'(diff_q[1]) + RW'(diff_q[2]) + RW'(diff_q[3]);
    // Row 0 starts a new candidate, so the old accumulator is discarded.
    acc_sum = (d_first ? '0 : acc) + SW'(row_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sad_out   <= '0;
      sad_valid <= 1'b0;
      c_idx     <= '0;
      c_final   <= 1'b0;
    end else begin
      sad_valid <= d_valid && d_last;
      if (d_valid) begin
        acc <= acc_sum;
        if (d_last) begin
          sad_out <= acc_sum;
          c_idx   <= d_idx;
          c_final <= d_final;
        end
      end
    end
  end

  // --------------------------------------------- stage 3: minimum
  // Strict less-than keeps the earlier index on ties; the all-ones seed
  // cannot be reached by a real SAD, so candidate 0 always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad <= '1;
      best_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= final_cmp;
      if (start_acc) begin
        best_sad <= '1;
        best_idx <= '0;
      end else if (sad_valid && (sad_out < best_sad)) begin
        best_sad <= sad_out;
        best_idx <= c_idx;
      end
    end
  end

endmodule

// File: tb/tb_sad44_min_search.sv
// tb_sad44_min_search
//   Directed bench for sad44_min_search. A single-candidate instance runs a
//   table of hand-computed SAD vectors with exact pipeline timing; a
//   four-candidate instance runs the min-search stream back-to-back, with
//   gaps and disturbances, and across an asynchronous mid-search reset.
module tb_sad44_min_search;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] cur_blk;
  logic [31:0]  cand_row;
  logic         cand_valid;
  logic         start1, start4;

  logic         busy1, sad_valid1, done1;
  logic [11:0]  sad_out1, best_sad1;
  logic [5:0]   best_idx1;

  logic         busy4, sad_valid4, done4;
  logic [11:0]  sad_out4, best_sad4;
  logic [1:0]   best_idx4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sad44_min_search #(.WORD_WIDETH(8), .CAND_NUM(1), .IDX_W(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .cur_blk(cur_blk), .start(start1),
    .cand_row(cand_row), .cand_valid(cand_valid), .busy(busy1),
    .sad_out(sad_out1), .sad_valid(sad_valid1), .best_sad(best_sad1),
    .best_idx(best_idx1), .done(done1)
  );

  sad44_min_search #(.WORD_WIDETH(8), .CAND_NUM(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .cur_blk(cur_blk), .start(start4),
    .cand_row(cand_row), .cand_valid(cand_valid), .busy(busy4),
    .sad_out(sad_out4), .sad_valid(sad_valid4), .best_sad(best_sad4),
    .best_idx(best_idx4), .done(done4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the four-candidate instance.
  logic [11:0] sad_q [$];
  int          done_cnt;

  always @(negedge clk) begin
    if (sad_valid4) sad_q.push_back(sad_out4);
    if (done4) done_cnt++;
  end

  // Single-candidate vector table
  typedef struct {
    logic [127:0] cur;
    logic [31:0]  row [4];
    logic [11:0]  sad;
  } vec_t;

  vec_t vt [7];

  // Four-candidate stream over a flat 8'h40 block: SADs 100, 40, 40, 75
  logic [31:0] cands [4][4];
  logic [11:0] exp_sads [4];

  task automatic run4(input bit gaps, input bit disturb, input bit junk_tail, input string tag);
    sad_q.delete();
    done_cnt = 0;
    cur_blk = {16{8'h40}};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy4), 32'd1);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        cand_row   = cands[c][r];
        cand_valid = 1'b1;
        if (disturb && c == 1 && r == 2) begin
          start4  = 1'b1;
          cur_blk = '0;
        end
        @(negedge clk);
        start4 = 1'b0;
        if (gaps) begin
          cand_valid = 1'b0;
          cand_row   = 32'hDEADBEEF;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
    end
    if (junk_tail) begin
      cand_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        cand_row = 32'hFF00FF00 ^ 32'(k);
        @(negedge clk);
      end
    end
    cand_valid = 1'b0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) @(negedge clk);
    check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_sad_pulses"}, 32'(sad_q.size()), 32'd4);
    for (int c = 0; c < 4 && c < sad_q.size(); c++)
      check($sformatf("%s_sad%0d", tag, c), 32'(sad_q[c]), 32'(exp_sads[c]));
    check({tag, "_best_sad"}, 32'(best_sad4), 32'd40);
    check({tag, "_best_idx"}, 32'(best_idx4), 32'd1);
    check({tag, "_busy_after_done"}, 32'(busy4), 32'd0);
    cur_blk = '0;
  endtask

  initial begin
    vt[0].cur = {16{8'h10}};
    vt[0].row = '{32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010};
    vt[0].sad = 12'd0;
    vt[1].cur = {16{8'h00}};
    vt[1].row = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[1].sad = 12'hFF0;
    vt[2].cur = {16{8'hFF}};
    vt[2].row = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vt[2].sad = 12'hFF0;
    // Pixel k = k; identical candidate exercises row/pixel pairing.
    vt[3].cur = 128'h000102030405060708090A0B0C0D0E0F;
    vt[3].row = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    vt[3].sad = 12'd0;
    // Same block, pixels mirrored within each row: 3+1+1+3 per row.
    vt[4].cur = 128'h000102030405060708090A0B0C0D0E0F;
    vt[4].row = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    vt[4].sad = 12'd32;
    // Pixel k = 16k against flat 0x80: 16 * (36 + 28).
    vt[5].cur = 128'h00102030405060708090A0B0C0D0E0F0;
    vt[5].row = '{32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080};
    vt[5].sad = 12'd1024;
    // Pixel k = k against flat 5: 15 + 55.
    vt[6].cur = 128'h000102030405060708090A0B0C0D0E0F;
    vt[6].row = '{32'h05050505, 32'h05050505, 32'h05050505, 32'h05050505};
    vt[6].sad = 12'd70;

    cands[0] = '{32'h40404040, 32'h40A44040, 32'h40404040, 32'h40404040};
    cands[1] = '{32'h18404040, 32'h40404040, 32'h40404040, 32'h40404040};
    cands[2] = '{32'h40404040, 32'h40404040, 32'h40405440, 32'h2C404040};
    cands[3] = '{32'h40404040, 32'h40404040, 32'h40404040, 32'h4040408B};
    exp_sads = '{12'd100, 12'd40, 12'd40, 12'd75};

    rst_n = 1'b0;
    cur_blk = '0;
    cand_row = '0;
    cand_valid = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    done_cnt = 0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_sad_out", 32'(sad_out4), 32'd0);
    check("rst_sad_valid", 32'(sad_valid4), 32'd0);
    check("rst_best_sad", 32'(best_sad4), 32'hFFF);
    check("rst_best_idx", 32'(best_idx4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-candidate searches: sad_valid one cycle after the last beat
    // edge's successor, done one cycle later.
    for (int v = 0; v < 7; v++) begin
      cur_blk = vt[v].cur;
      start1  = 1'b1;
      @(negedge clk);
      start1  = 1'b0;
      cur_blk = ~vt[v].cur;  // must not matter once latched
      for (int r = 0; r < 4; r++) begin
        cand_row   = vt[v].row[r];
        cand_valid = 1'b1;
        @(negedge clk);
      end
      cand_valid = 1'b0;
      check($sformatf("v%0d_no_early_valid", v), 32'(sad_valid1), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_sad_valid", v), 32'(sad_valid1), 32'd1);
      check($sformatf("v%0d_sad_out", v), 32'(sad_out1), 32'(vt[v].sad));
      check($sformatf("v%0d_busy_before_done", v), 32'(busy1), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_done", v), 32'(done1), 32'd1);
      check($sformatf("v%0d_busy", v), 32'(busy1), 32'd0);
      check($sformatf("v%0d_best_sad", v), 32'(best_sad1), 32'(vt[v].sad));
      check($sformatf("v%0d_best_idx", v), 32'(best_idx1), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), 32'(done1), 32'd0);
    end

    // Back-to-back stream.
    run4(1'b0, 1'b0, 1'b0, "b2b");

    // Junk beats in IDLE, then gaps, a mid-search start and block change,
    // and trailing beats after the last candidate.
    cand_valid = 1'b1;
    cand_row   = 32'h01234567;
    repeat (3) @(negedge clk);
    cand_valid = 1'b0;
    check("idle_beats_ignored", 32'(best_sad4), 32'd40);
    run4(1'b1, 1'b1, 1'b1, "gap");

    // Asynchronous reset during candidate 2.
    sad_q.delete();
    done_cnt = 0;
    cur_blk = {16{8'h40}};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4 && !(c == 2 && r == 2); r++) begin
        cand_row   = cands[c][r];
        cand_valid = 1'b1;
        @(negedge clk);
      end
    end
    cand_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_sad_out", 32'(sad_out4), 32'd0);
    check("arst_sad_valid", 32'(sad_valid4), 32'd0);
    check("arst_best_sad", 32'(best_sad4), 32'hFFF);
    check("arst_best_idx", 32'(best_idx4), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_no_done", 32'(done_cnt), 32'd0);

    run4(1'b0, 1'b0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sad44_min_search.md
Name: sad44_min_search

Overview:
- Downstream stage of the 4x4x8-bit current-block register.
- Takes the 16 latched current-block pixels, then receives a stream of candidate blocks. Each candidate arrives as 4 row-beats of 4 pixels in the same 32-bit row format the register loads.
- Computes the 4x4 sum of absolute differences (SAD) per candidate and tracks the minimum SAD and its candidate index over one full search.
- Reports the best match to the motion-vector logic.

Parameters:
WORD_WIDETH, 8, pixel width in bits
CAND_NUM, 64, candidates per search (>=1)
IDX_W, 6, candidate index width; 2**IDX_W >= CAND_NUM

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cur_blk  in  WORD_WIDETH*16  current block {pe_in00..pe_in15}; pe_in00 at MSBs, row-major
start  in  1  begin search; sampled in IDLE only
cand_row  in  WORD_WIDETH*4  one candidate row; leftmost pixel at MSBs
cand_valid  in  1  cand_row valid this cycle; gaps allowed
busy  out  1  high from start acceptance until done
sad_out  out  WORD_WIDETH+4  SAD of the most recent completed candidate
sad_valid  out  1  one-cycle pulse, sad_out new
best_sad  out  WORD_WIDETH+4  running minimum SAD
best_idx  out  IDX_W  index of best_sad candidate
done  out  1  one-cycle pulse, search complete

Behaviour:
- Reset (async, rst_n=0) forces IDLE and clears all registers. Outputs: busy=0, sad_out=0, sad_valid=0, best_sad=all ones, best_idx=0, done=0. Internal row counter, candidate counter, accumulator and pipeline valid bits = 0.
- Reset asserted mid-search aborts the search immediately. No done pulse is produced.
- States:
  - IDLE: start=1 latches cur_blk internally, loads best_sad=all ones, best_idx=0, clears counters, moves to RUN; busy=1 from the next cycle.
  - RUN: accepts beats while cand_valid=1.
  - DONE_WAIT: entered after the last beat of candidate CAND_NUM-1 is accepted. Further cand_valid is ignored. Returns to IDLE on the edge that commits the final compare.
- Pixel pairing: row counter r (0..3) selects current-block row r, i.e. pe_in(4r)..pe_in(4r+3). Pixel j of cand_row pairs with pe_in(4r+j). cur_blk changes after start have no effect.
- Pipeline, beat accepted at edge t:
  - Edge t: 4 absolute differences registered (WORD_WIDETH bits each, unsigned, |a-b|).
  - Edge t+1: row sum (WORD_WIDETH+2 bits) added to the accumulator. Row 0 loads the accumulator rather than adding. For row 3, sad_out <= acc+rowsum and sad_valid=1 for exactly one cycle.
  - Edge t+2: the row-3 result is compared. If sad_out < best_sad (strict), best_sad <= sad_out and best_idx <= candidate index. Ties keep the earlier index. Candidate 0 always wins against the all-ones init.
  - If this is candidate CAND_NUM-1: done=1 for one cycle at t+2, busy=0 at t+2, state -> IDLE.
- Counters:
  - Row counter increments per accepted beat and wraps 3->0.
  - Candidate index increments on wrap, from 0 to CAND_NUM-1.
  - No arithmetic overflow: max SAD = 16*(2**WORD_WIDETH-1) fits in WORD_WIDETH+4 bits.
- Back-to-back beats are sustained at one per cycle with no stall. cand_valid gaps hold all pipeline contents unchanged except in-flight stages, which drain normally.
- start while busy=1 is ignored. cand_valid in IDLE is ignored.
- A new start is accepted on the cycle after done. best_sad and best_idx hold their values until that start.

Test Plan:
- cur_blk all 8'h10; 1 candidate (CAND_NUM=1), all rows 8'h10 -> sad_valid 2 cycles after the 4th beat with sad_out=0; done next cycle with best_sad=0, best_idx=0.
- cur_blk all 8'h00; candidate all 8'hFF -> sad_out=12'hFF0 (4080). Repeat with cur all 8'hFF, cand all 8'h00 -> 12'hFF0 (abs symmetry).
- CAND_NUM=4, candidates with SADs 100, 40, 40, 75, back-to-back beats -> sad_valid pulses 4 times; best_sad=40, best_idx=1 (tie keeps earlier); one done pulse; busy low after done.
- Same stream with random 1-3 cycle cand_valid gaps -> identical sad_out sequence and best results; extra cand_valid after the last beat is ignored.
- start pulsed again mid-search, and cand_valid asserted in IDLE -> no effect on counters or results.
- rst_n dropped asynchronously mid-candidate 2 -> outputs immediately take reset values, no done. A fresh search afterwards gives correct results, with rows aligned starting from row 0.
